fetch_stage: RTL

- IF stage of the RV64 datapath: holds the PC, issues word fetches to instruction memory, and presents {instruction, pc} to decode through a valid/ready register.
- Decode feeds the instruction word straight into immediate generation and the register file.
- Accepts taken-branch redirects (target = pc + B-type immediate, computed downstream) and squashes wrong-path fetches.
- One outstanding memory request; one-entry skid buffer.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_skid_buffer.sv | 52 +++++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Constants shared by fetch, decode and immediate generation: FSM encodings,
// default NOP word, PC step and RV base opcodes.
package fetch_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int unsigned PC_STEP       = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register; clear beats load beats unload.
module fetch_skid_buffer #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, single-outstanding fetch FSM, valid/ready decode register plus skid.
// Define FETCH_MISALIGN_TRAP_EN to trap (and halt) on misaligned redirect targets.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instruction,
    output logic [XLEN-1:0] id_pc,
    output logic            fetch_misaligned
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            squash_q, squash_d;
    logic            misalign_q, misalign_d;
    logic            id_valid_q, id_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;

    logic            skid_valid, skid_load, skid_unload, skid_clear;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            req_fire, id_xfer, resp_take, redirect_bad;
    logic [XLEN-1:0] redirect_tgt;

    assign req_fire  = (state_q == ST_REQ) && imem_req_ready;
    assign id_xfer   = id_valid_q && id_ready;
    assign resp_take = (state_q == ST_WAIT) && imem_resp_valid && !squash_q && !redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_d   = redirect_valid ? redirect_bad : misalign_q;
`else
    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign redirect_bad = 1'b0;
    assign misalign_d   = 1'b0;
`endif

    fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (imem_resp_data),
        .pc_i     (pc_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    // Decode register: the skid can only be full while the register is full,
    // so a response never competes with a skid refill.
    always_comb begin
        id_valid_d  = id_valid_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            skid_clear = 1'b1;
        end else if (id_xfer) begin
            if (skid_valid) begin
                id_instr_d  = skid_instr;
                id_pc_d     = skid_pc;
                skid_unload = 1'b1;
            end else if (resp_take) begin
                id_instr_d = imem_resp_data;
                id_pc_d    = pc_q;
            end else begin
                id_valid_d = 1'b0;
            end
        end else if (resp_take) begin
            if (!id_valid_q) begin
                id_valid_d = 1'b1;
                id_instr_d = imem_resp_data;
                id_pc_d    = pc_q;
            end else begin
                skid_load = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        case (state_q)
            ST_IDLE: if ((!skid_valid || redirect_valid) && !misalign_d) state_d = ST_REQ;
            ST_REQ:  if (req_fire) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        pc_d    = pc_q + XLEN'(PC_STEP);
                        state_d = skid_load ? ST_IDLE : ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A stale response can only land outside WAIT after a trap halted fetch.
        if ((state_q != ST_WAIT) && imem_resp_valid) squash_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_tgt;
            if (state_q == ST_REQ) begin
                if (req_fire) begin
                    squash_d = 1'b1;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end else if (state_q == ST_WAIT) begin
                squash_d = !imem_resp_valid;
                state_d  = imem_resp_valid ? ST_REQ : ST_WAIT;
            end
            if (redirect_bad) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            misalign_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            misalign_q <= misalign_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    assign imem_req_valid   = (state_q == ST_REQ);
    assign imem_addr        = pc_q;
    assign id_valid         = id_valid_q;
    assign id_instruction   = id_valid_q ? id_instr_q : NOP_INSTR;
    assign id_pc            = id_pc_q;
    assign fetch_misaligned = misalign_q;

endmodule
